// File: rtl/rq_arbiter_if.sv
// Requester-side and formatter-side RQ buses of the arbiter, bundled for port connection.
// master: the arbiter; slave: the requesters/formatter environment.
interface rq_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 256
);
  localparam int unsigned KEEP_W = DATA_WIDTH / 32;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_is_write;
  logic [NUM_REQ-1:0]            req_is_read;
  logic [NUM_REQ-1:0]            req_sop;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*64-1:0]         req_addr;
  logic [NUM_REQ*11-1:0]         req_dword_count;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_payload;
  logic [NUM_REQ*KEEP_W-1:0]     req_payload_keep;
  logic [7:0]                    req_tag;

  logic                          rq_ready;
  logic                          rq_valid;
  logic                          rq_is_write;
  logic                          rq_is_read;
  logic                          rq_sop;
  logic                          rq_last;
  logic [63:0]                   rq_addr;
  logic [10:0]                   rq_dword_count;
  logic [7:0]                    rq_tag;
  logic [15:0]                   rq_requester_id;
  logic [2:0]                    rq_tc;
  logic [2:0]                    rq_attr;
  logic [DATA_WIDTH-1:0]         rq_payload;
  logic [KEEP_W-1:0]             rq_payload_keep;

  modport master (
    input  req_valid, req_is_write, req_is_read, req_sop, req_last, req_addr,
           req_dword_count, req_payload, req_payload_keep, rq_ready,
    output req_ready, req_tag, rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last,
           rq_addr, rq_dword_count, rq_tag, rq_requester_id, rq_tc, rq_attr,
           rq_payload, rq_payload_keep
  );

  modport slave (
    output req_valid, req_is_write, req_is_read, req_sop, req_last, req_addr,
           req_dword_count, req_payload, req_payload_keep, rq_ready,
    input  req_ready, req_tag, rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last,
           rq_addr, rq_dword_count, rq_tag, rq_requester_id, rq_tc, rq_attr,
           rq_payload, rq_payload_keep
  );
endinterface

// File: rtl/rq_arbiter.sv
// Round-robin, packet-locked arbiter sharing the RQ formatter between DMA requesters,
// with read-tag allocation, completion-driven tag free and completion owner lookup.
module rq_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned TAG_COUNT  = 32,
  parameter logic [7:0]  WRITE_TAG  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  rq_arbiter_if.master       bus,
  input  logic [15:0]        cfg_requester_id,
  input  logic               rc_desc_valid,
  input  logic [7:0]         rc_tag,
  input  logic               rc_request_completed,
  output logic [2:0]         rc_owner,
  output logic               rc_owner_valid,
  output logic [6:0]         tags_outstanding,
  output logic               tag_error
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned MAX_TAGS = 64;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned KEEP_W   = DATA_WIDTH / 32;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]          state, state_nxt;
  logic [IDX_W-1:0]    grant, grant_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [7:0]          tag_q, tag_nxt;
  logic [MAX_TAGS-1:0] busy, busy_nxt;
  logic [IDX_W-1:0]    owner [MAX_TAGS];
  logic [CNT_W-1:0]    cnt_nxt;
  logic                err_nxt;

  logic [NUM_REQ-1:0]  elig;
  logic                found, win_write, free_any, alloc, free_hit, beat;
  logic [IDX_W-1:0]    win;
  logic [TAG_W-1:0]    free_tag;

  logic                g_valid, g_write, g_read, g_sop, g_last;
  logic [63:0]         g_addr;
  logic [10:0]         g_dw;
  logic [DATA_WIDTH-1:0] g_payload;
  logic [KEEP_W-1:0]   g_keep;

  logic [TAG_W-1:0]    rc_idx;
  logic                rc_in_range;

  assign rc_idx      = rc_tag[TAG_W-1:0];
  assign rc_in_range = rc_tag < 8'(TAG_COUNT);

  // Completion steering: owner lookup is valid only for in-range busy tags.
  assign rc_owner       = owner[rc_idx];
  assign rc_owner_valid = rc_desc_valid & rc_in_range & busy[rc_idx];

  assign bus.req_tag = tag_q;
  assign bus.rq_tc   = 3'd0;
  assign bus.rq_attr = 3'd0;

  // Fields of the currently granted requester.
  always_comb begin : grant_mux
    g_valid   = 1'b0;
    g_write   = 1'b0;
    g_read    = 1'b0;
    g_sop     = 1'b0;
    g_last    = 1'b0;
    g_addr    = '0;
    g_dw      = '0;
    g_payload = '0;
    g_keep    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        g_valid   = bus.req_valid[i];
        g_write   = bus.req_is_write[i];
        g_read    = bus.req_is_read[i];
        g_sop     = bus.req_sop[i];
        g_last    = bus.req_last[i];
        g_addr    = bus.req_addr[i*64 +: 64];
        g_dw      = bus.req_dword_count[i*11 +: 11];
        g_payload = bus.req_payload[i*DATA_WIDTH +: DATA_WIDTH];
        g_keep    = bus.req_payload_keep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  // Formatter port is driven only while a packet is locked in.
  always_comb begin : port_out
    bus.req_ready       = '0;
    bus.rq_valid        = 1'b0;
    bus.rq_is_write     = 1'b0;
    bus.rq_is_read      = 1'b0;
    bus.rq_sop          = 1'b0;
    bus.rq_last         = 1'b0;
    bus.rq_addr         = '0;
    bus.rq_dword_count  = '0;
    bus.rq_tag          = '0;
    bus.rq_requester_id = '0;
    bus.rq_payload      = '0;
    bus.rq_payload_keep = '0;
    if (state == XFER) begin
      bus.rq_valid        = g_valid;
      bus.rq_is_write     = g_write;
      bus.rq_is_read      = g_read;
      bus.rq_sop          = g_sop;
      bus.rq_last         = g_last;
      bus.rq_addr         = g_addr;
      bus.rq_dword_count  = g_dw;
      bus.rq_tag          = tag_q;
      bus.rq_requester_id = cfg_requester_id;
      bus.rq_payload      = g_payload;
      bus.rq_payload_keep = g_keep;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant == IDX_W'(i)) bus.req_ready[i] = bus.rq_ready;
      end
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    tag_nxt   = tag_q;
    busy_nxt  = busy;
    cnt_nxt   = tags_outstanding;
    err_nxt   = tag_error;
    alloc     = 1'b0;
    free_hit  = 1'b0;
    free_any  = 1'b0;
    free_tag  = '0;
    found     = 1'b0;
    win       = '0;
    win_write = 1'b0;
    elig      = '0;

    for (int unsigned t = 0; t < TAG_COUNT; t++) begin
      if (!free_any && !busy[t]) begin
        free_any = 1'b1;
        free_tag = TAG_W'(t);
      end
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] & bus.req_sop[i] & (bus.req_is_write[i] | free_any);
    end

    // Rotating priority: scan indices at/after the pointer first, then wrap.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[i] && (IDX_W'(i) >= ptr)) begin
        found     = 1'b1;
        win       = IDX_W'(i);
        win_write = bus.req_is_write[i];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[i] && (IDX_W'(i) < ptr)) begin
        found     = 1'b1;
        win       = IDX_W'(i);
        win_write = bus.req_is_write[i];
      end
    end

    beat = g_valid & bus.rq_ready;

    case (state)
      ARB: begin
        if (found) begin
          grant_nxt = win;
          tag_nxt   = win_write ? WRITE_TAG : 8'(free_tag);
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          if (g_sop && g_read) alloc = 1'b1;
          if (g_last) begin
            ptr_nxt   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
            state_nxt = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase

    if (rc_desc_valid && rc_request_completed && rc_in_range) begin
      if (busy[rc_idx]) free_hit = 1'b1;
      else              err_nxt  = 1'b1;
    end

    if (free_hit) busy_nxt[rc_idx] = 1'b0;
    if (alloc)    busy_nxt[tag_q[TAG_W-1:0]] = 1'b1;
    cnt_nxt = tags_outstanding + CNT_W'(alloc) - CNT_W'(free_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ARB;
      grant            <= '0;
      ptr              <= '0;
      tag_q            <= '0;
      busy             <= '0;
      tags_outstanding <= '0;
      tag_error        <= 1'b0;
    end else begin
      state            <= state_nxt;
      grant            <= grant_nxt;
      ptr              <= ptr_nxt;
      tag_q            <= tag_nxt;
      busy             <= busy_nxt;
      tags_outstanding <= cnt_nxt;
      tag_error        <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned t = 0; t < MAX_TAGS; t++) owner[t] <= '0;
    end else if (alloc) begin
      owner[tag_q[TAG_W-1:0]] <= grant;
    end
  end

endmodule

// File: tb/tb_rq_arbiter.sv
// Directed bench for rq_arbiter: arbitration order, packet locking, tag pool, completion handling, reset.
module tb_rq_arbiter;
  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned DATA_WIDTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_requester_id;
  logic        rc_desc_valid;
  logic [7:0]  rc_tag;
  logic        rc_request_completed;
  logic [2:0]  rc_owner;
  logic        rc_owner_valid;
  logic [6:0]  tags_outstanding;
  logic        tag_error;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] A0 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] A1 = 64'h0000_0002_0000_1000;
  localparam logic [63:0] A2 = 64'h0000_0003_0000_2000;
  localparam logic [255:0] PL0 = {4{64'hA5A5_0000_1111_2222}};
  localparam logic [255:0] PB0 = {4{64'hB0B0_0000_0000_0000}};
  localparam logic [255:0] PB1 = {4{64'hB1B1_0000_0000_0001}};
  localparam logic [255:0] PB2 = {4{64'hB2B2_0000_0000_0002}};

  always #5 clk = ~clk;

  rq_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  rq_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .TAG_COUNT(32), .WRITE_TAG(8'hFF)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus),
    .cfg_requester_id     (cfg_requester_id),
    .rc_desc_valid        (rc_desc_valid),
    .rc_tag               (rc_tag),
    .rc_request_completed (rc_request_completed),
    .rc_owner             (rc_owner),
    .rc_owner_valid       (rc_owner_valid),
    .tags_outstanding     (tags_outstanding),
    .tag_error            (tag_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic r, input logic sop,
                         input logic last, input logic [63:0] addr, input logic [10:0] dw,
                         input logic [255:0] pl);
    bus.req_valid[i]                  = v;
    bus.req_is_write[i]               = w;
    bus.req_is_read[i]                = r;
    bus.req_sop[i]                    = sop;
    bus.req_last[i]                   = last;
    bus.req_addr[i*64 +: 64]          = addr;
    bus.req_dword_count[i*11 +: 11]   = dw;
    bus.req_payload[i*256 +: 256]     = pl;
    bus.req_payload_keep[i*8 +: 8]    = 8'hFF;
  endtask

  task automatic clear_all();
    bus.req_valid        = '0;
    bus.req_is_write     = '0;
    bus.req_is_read      = '0;
    bus.req_sop          = '0;
    bus.req_last         = '0;
    bus.req_addr         = '0;
    bus.req_dword_count  = '0;
    bus.req_payload      = '0;
    bus.req_payload_keep = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    settle();
    checks++; if (bus.rq_valid !== 1'b0) begin errors++; $display("FAIL reset_rq_valid got=%0h exp=0", bus.rq_valid); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got=%0h exp=0", bus.req_ready); end
    checks++; if (bus.req_tag !== 8'h00) begin errors++; $display("FAIL reset_req_tag got=%0h exp=0", bus.req_tag); end
    checks++; if (bus.rq_tag !== 8'h00) begin errors++; $display("FAIL reset_rq_tag got=%0h exp=0", bus.rq_tag); end
    checks++; if (bus.rq_addr !== 64'h0) begin errors++; $display("FAIL reset_rq_addr got=%0h exp=0", bus.rq_addr); end
    checks++; if (tags_outstanding !== 7'd0) begin errors++; $display("FAIL reset_tags got=%0d exp=0", tags_outstanding); end
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL reset_tag_error got=%0h exp=0", tag_error); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    set_req(0, 1, 1, 0, 1, 1, A0, 11'd4, PL0);
    settle();
    checks++; if (bus.rq_valid !== 1'b0) begin errors++; $display("FAIL sw_arb_cycle got=%0h exp=0", bus.rq_valid); end
    settle();
    checks++; if (bus.rq_valid !== 1'b1) begin errors++; $display("FAIL sw_rq_valid got=%0h exp=1", bus.rq_valid); end
    checks++; if (bus.rq_is_write !== 1'b1 || bus.rq_is_read !== 1'b0) begin errors++; $display("FAIL sw_kind got=w%0h r%0h exp=w1 r0", bus.rq_is_write, bus.rq_is_read); end
    checks++; if (bus.rq_tag !== 8'hFF) begin errors++; $display("FAIL sw_rq_tag got=%0h exp=ff", bus.rq_tag); end
    checks++; if (bus.req_tag !== 8'hFF) begin errors++; $display("FAIL sw_req_tag got=%0h exp=ff", bus.req_tag); end
    checks++; if (bus.rq_addr !== A0) begin errors++; $display("FAIL sw_addr got=%0h exp=%0h", bus.rq_addr, A0); end
    checks++; if (bus.rq_dword_count !== 11'd4) begin errors++; $display("FAIL sw_dw got=%0d exp=4", bus.rq_dword_count); end
    checks++; if (bus.rq_sop !== 1'b1 || bus.rq_last !== 1'b1) begin errors++; $display("FAIL sw_sop_last got=%0h%0h exp=11", bus.rq_sop, bus.rq_last); end
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL sw_req_ready got=%0b exp=001", bus.req_ready); end
    checks++; if (bus.rq_requester_id !== 16'h0A5C) begin errors++; $display("FAIL sw_reqid got=%0h exp=a5c", bus.rq_requester_id); end
    checks++; if (bus.rq_payload !== PL0 || bus.rq_payload_keep !== 8'hFF) begin errors++; $display("FAIL sw_payload got=%0h keep=%0h", bus.rq_payload, bus.rq_payload_keep); end
    checks++; if (bus.rq_tc !== 3'd0 || bus.rq_attr !== 3'd0) begin errors++; $display("FAIL sw_tc_attr got=%0h/%0h exp=0/0", bus.rq_tc, bus.rq_attr); end
    tick();
    // pointer now at 1: requester 1 beats requester 0
    set_req(1, 1, 1, 0, 1, 1, A1, 11'd1, PB0);
    settle();
    settle();
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL sw_ptr_grant got=%0b exp=010", bus.req_ready); end
    checks++; if (bus.rq_addr !== A1) begin errors++; $display("FAIL sw_ptr_addr got=%0h exp=%0h", bus.rq_addr, A1); end
    tick();
    set_req(1, 0, 0, 0, 0, 0, 64'h0, 11'd0, 256'h0);
    settle();
    checks++; if (bus.rq_valid !== 1'b0) begin errors++; $display("FAIL sw_gap got=%0h exp=0", bus.rq_valid); end
    settle();
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL sw_second got=%0b exp=001", bus.req_ready); end
    tick();
    clear_all();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy;
    logic [63:0] exp_addr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1, 1, 0, 1, 1, A0, 11'd1, PB0);
    set_req(1, 1, 1, 0, 1, 1, A1, 11'd1, PB1);
    set_req(2, 1, 1, 0, 1, 1, A2, 11'd1, PB2);
    for (int n = 0; n < 6; n++) begin
      exp_rdy  = 3'b001 << (n % 3);
      exp_addr = (n % 3 == 0) ? A0 : ((n % 3 == 1) ? A1 : A2);
      settle();
      checks++; if (bus.rq_valid !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d] got=%0h exp=0", n, bus.rq_valid); end
      settle();
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got=%0b exp=%0b", n, bus.req_ready, exp_rdy); end
      checks++; if (bus.rq_addr !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d] got=%0h exp=%0h", n, bus.rq_addr, exp_addr); end
    end
    tick();
    clear_all();
  endtask

  task automatic test_multi_beat();
    tick();
    set_req(1, 1, 1, 0, 1, 0, A1, 11'd24, PB0);
    tick();
    set_req(0, 1, 1, 0, 1, 1, A0, 11'd1, PL0);
    settle();
    checks++; if (bus.req_ready !== 3'b010 || bus.rq_sop !== 1'b1 || bus.rq_last !== 1'b0) begin errors++; $display("FAIL mb_beat0 rdy=%0b sop=%0h last=%0h exp 010/1/0", bus.req_ready, bus.rq_sop, bus.rq_last); end
    checks++; if (bus.rq_payload !== PB0) begin errors++; $display("FAIL mb_beat0_data got=%0h exp=%0h", bus.rq_payload, PB0); end
    tick();
    set_req(1, 1, 1, 0, 0, 0, A1, 11'd24, PB1);
    bus.rq_ready = 1'b0;
    settle();
    checks++; if (bus.rq_valid !== 1'b1 || bus.req_ready !== 3'b000) begin errors++; $display("FAIL mb_stall0 valid=%0h rdy=%0b exp 1/000", bus.rq_valid, bus.req_ready); end
    checks++; if (bus.rq_payload !== PB1) begin errors++; $display("FAIL mb_stall0_data got=%0h exp=%0h", bus.rq_payload, PB1); end
    tick();
    settle();
    checks++; if (bus.rq_addr !== A1 || bus.req_ready !== 3'b000) begin errors++; $display("FAIL mb_stall1 addr=%0h rdy=%0b", bus.rq_addr, bus.req_ready); end
    tick();
    bus.rq_ready = 1'b1;
    settle();
    checks++; if (bus.req_ready !== 3'b010 || bus.rq_payload !== PB1) begin errors++; $display("FAIL mb_beat1 rdy=%0b data=%0h", bus.req_ready, bus.rq_payload); end
    tick();
    set_req(1, 1, 1, 0, 0, 1, A1, 11'd24, PB2);
    settle();
    checks++; if (bus.req_ready !== 3'b010 || bus.rq_last !== 1'b1 || bus.rq_payload !== PB2) begin errors++; $display("FAIL mb_beat2 rdy=%0b last=%0h data=%0h", bus.req_ready, bus.rq_last, bus.rq_payload); end
    tick();
    set_req(1, 0, 0, 0, 0, 0, 64'h0, 11'd0, 256'h0);
    settle();
    checks++; if (bus.rq_valid !== 1'b0) begin errors++; $display("FAIL mb_after_last got=%0h exp=0", bus.rq_valid); end
    tick();
    settle();
    checks++; if (bus.req_ready !== 3'b001 || bus.rq_addr !== A0) begin errors++; $display("FAIL mb_req0_grant rdy=%0b addr=%0h", bus.req_ready, bus.rq_addr); end
    tick();
    clear_all();
  endtask

  task automatic test_tags();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(2, 1, 0, 1, 1, 1, A2, 11'd1, PB2);
    for (int n = 0; n < 32; n++) begin
      settle();
      settle();
      checks++; if (bus.rq_tag !== 8'(n) || bus.rq_is_read !== 1'b1) begin errors++; $display("FAIL tag_issue[%0d] tag=%0d read=%0h", n, bus.rq_tag, bus.rq_is_read); end
      checks++; if (tags_outstanding !== 7'(n)) begin errors++; $display("FAIL tag_count[%0d] got=%0d exp=%0d", n, tags_outstanding, n); end
    end
    tick();
    settle();
    checks++; if (tags_outstanding !== 7'd32) begin errors++; $display("FAIL tag_full got=%0d exp=32", tags_outstanding); end
    tick();
    set_req(0, 1, 1, 0, 1, 1, A0, 11'd2, PL0);
    settle();
    checks++; if (bus.rq_valid !== 1'b0) begin errors++; $display("FAIL tag_read_waits got=%0h exp=0", bus.rq_valid); end
    tick();
    settle();
    checks++; if (bus.req_ready !== 3'b001 || bus.rq_tag !== 8'hFF) begin errors++; $display("FAIL tag_write_passes rdy=%0b tag=%0h", bus.req_ready, bus.rq_tag); end
    tick();
    set_req(0, 0, 0, 0, 0, 0, 64'h0, 11'd0, 256'h0);
    tick();
    rc_desc_valid = 1'b1; rc_tag = 8'd5; rc_request_completed = 1'b1;
    settle();
    checks++; if (rc_owner !== 3'd2 || rc_owner_valid !== 1'b1) begin errors++; $display("FAIL tag_owner owner=%0d valid=%0h exp 2/1", rc_owner, rc_owner_valid); end
    tick();
    rc_desc_valid = 1'b0;
    settle();
    checks++; if (tags_outstanding !== 7'd31 || bus.rq_valid !== 1'b0) begin errors++; $display("FAIL tag_freed cnt=%0d valid=%0h exp 31/0", tags_outstanding, bus.rq_valid); end
    tick();
    settle();
    checks++; if (bus.rq_tag !== 8'd5 || bus.req_ready !== 3'b100) begin errors++; $display("FAIL tag_reuse tag=%0d rdy=%0b exp 5/100", bus.rq_tag, bus.req_ready); end
    tick();
    clear_all();
    settle();
    checks++; if (tags_outstanding !== 7'd32) begin errors++; $display("FAIL tag_refull got=%0d exp=32", tags_outstanding); end
  endtask

  task automatic test_tag_error();
    tick();
    rc_desc_valid = 1'b1; rc_tag = 8'd7; rc_request_completed = 1'b1;
    settle();
    checks++; if (rc_owner_valid !== 1'b1 || rc_owner !== 3'd2) begin errors++; $display("FAIL err_first owner=%0d valid=%0h", rc_owner, rc_owner_valid); end
    tick();
    settle();
    checks++; if (rc_owner_valid !== 1'b0 || tags_outstanding !== 7'd31 || tag_error !== 1'b0) begin errors++; $display("FAIL err_pre valid=%0h cnt=%0d err=%0h", rc_owner_valid, tags_outstanding, tag_error); end
    tick();
    rc_tag = 8'h40;
    settle();
    checks++; if (tag_error !== 1'b1 || tags_outstanding !== 7'd31) begin errors++; $display("FAIL err_set err=%0h cnt=%0d exp 1/31", tag_error, tags_outstanding); end
    checks++; if (rc_owner_valid !== 1'b0) begin errors++; $display("FAIL err_oor_owner got=%0h exp=0", rc_owner_valid); end
    tick();
    rc_desc_valid = 1'b0; rc_request_completed = 1'b0;
    settle();
    checks++; if (tag_error !== 1'b1 || tags_outstanding !== 7'd31) begin errors++; $display("FAIL err_sticky err=%0h cnt=%0d exp 1/31", tag_error, tags_outstanding); end
  endtask

  task automatic test_reset_mid_packet();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(2, 1, 0, 1, 1, 1, A2, 11'd1, PB2);
    repeat (6) tick();
    clear_all();
    set_req(0, 1, 1, 0, 1, 1, A0, 11'd1, PL0);
    settle();
    checks++; if (tags_outstanding !== 7'd3 || tag_error !== 1'b0) begin errors++; $display("FAIL rmp_three cnt=%0d err=%0h exp 3/0", tags_outstanding, tag_error); end
    tick();
    tick();
    clear_all();
    set_req(1, 1, 1, 0, 1, 0, A1, 11'd32, PB0);
    tick();
    tick();
    set_req(1, 1, 1, 0, 0, 0, A1, 11'd32, PB1);
    settle();
    checks++; if (bus.rq_valid !== 1'b1 || bus.req_ready !== 3'b010) begin errors++; $display("FAIL rmp_mid valid=%0h rdy=%0b", bus.rq_valid, bus.req_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_all();
    settle();
    checks++; if (bus.rq_valid !== 1'b0 || bus.req_ready !== 3'b000) begin errors++; $display("FAIL rmp_idle valid=%0h rdy=%0b", bus.rq_valid, bus.req_ready); end
    checks++; if (tags_outstanding !== 7'd0) begin errors++; $display("FAIL rmp_tags got=%0d exp=0", tags_outstanding); end
    tick();
    set_req(0, 1, 1, 0, 1, 1, A0, 11'd1, PL0);
    set_req(1, 1, 1, 0, 1, 1, A1, 11'd1, PB1);
    set_req(2, 1, 1, 0, 1, 1, A2, 11'd1, PB2);
    settle();
    settle();
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rmp_ptr got=%0b exp=001", bus.req_ready); end
    tick();
    clear_all();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    bus.rq_ready         = 1'b1;
    cfg_requester_id     = 16'h0A5C;
    rc_desc_valid        = 1'b0;
    rc_tag               = 8'd0;
    rc_request_completed = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_multi_beat();
    test_tags();
    test_tag_error();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rq_arbiter.md
Name: rq_arbiter

Overview:
Shares the single RQ formatter port between NUM_REQ DMA requesters, such as the DMA write engine, the DMA read engine and a future descriptor fetcher.
- Arbitration is round-robin, and a grant stays locked for a whole multi-beat packet.
- The block allocates PCIe tags for read requests from a local pool.
- It frees those tags on RC completion and reports which requester owns each incoming completion, so RC data can be steered.
- It sits between the user DMA engines and the RQ formatter inside the PCIe user logic.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 256, RQ payload width in bits
TAG_COUNT, 32, read tags available; tags 0..TAG_COUNT-1 (max 64)
WRITE_TAG, 8'hFF, tag driven on all write requests

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accepted
req_is_write  in  NUM_REQ  request is a memory write
req_is_read  in  NUM_REQ  request is a memory read
req_sop  in  NUM_REQ  first beat of packet
req_last  in  NUM_REQ  last beat of packet
req_addr  in  NUM_REQ*64  host address, requester i at [64i+63:64i]
req_dword_count  in  NUM_REQ*11  DW length
req_payload  in  NUM_REQ*DATA_WIDTH  beat data
req_payload_keep  in  NUM_REQ*DATA_WIDTH/32  DW enables
req_tag  out  8  tag assigned to the current granted packet
cfg_requester_id  in  16  our Bus:Dev:Func
rq_ready  in  1  formatter ready
rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last  out  1 each  to formatter
rq_addr  out  64  to formatter
rq_dword_count  out  11  to formatter
rq_tag  out  8  to formatter
rq_requester_id  out  16  equals cfg_requester_id
rq_tc, rq_attr  out  3 each  constant 0
rq_payload  out  DATA_WIDTH  to formatter
rq_payload_keep  out  DATA_WIDTH/32  to formatter
rc_desc_valid  in  1  RC descriptor strobe
rc_tag  in  8  completion tag
rc_request_completed  in  1  final completion for this tag
rc_owner  out  3  requester index that owns rc_tag (combinational)
rc_owner_valid  out  1  rc_desc_valid, rc_tag < TAG_COUNT and tag busy
tags_outstanding  out  7  count of busy tags
tag_error  out  1  sticky: completion freed a tag that was not busy

Behaviour:
- Reset values:
  - Outputs: all rq_* outputs 0; req_ready 0; req_tag 0; tags_outstanding 0; tag_error 0.
  - Internal state: busy-tag vector all clear; round-robin pointer at 0; FSM in ARB.
- Reset mid-packet: the packet is abandoned with no completing beats, and all tags are freed.
- FSM state ARB:
  - Requester i is eligible when req_valid[i] & req_sop[i] & (req_is_write[i] | a free tag exists).
  - Search starts at the pointer and wraps modulo NUM_REQ; the first eligible requester wins.
  - On a win, register grant=i and register req_tag. For reads this is the lowest-index free tag; for writes it is WRITE_TAG.
  - Move to XFER. Arbitration latency is 1 cycle from valid to first rq_valid.
  - No eligible requester: stay in ARB.
  - rq_valid=0 in ARB.
- FSM state XFER:
  - rq_* fields are a combinational mux of requester grant; rq_tag=req_tag.
  - rq_valid = req_valid[grant]; req_ready[grant] = rq_ready; other req_ready bits are 0.
  - A beat transfers when rq_valid & rq_ready.
  - When the sop beat transfers and the packet is a read, mark the tag busy and record owner[tag]=grant.
  - When the last beat transfers, set pointer=grant+1 (wrapping) and return to ARB next cycle.
  - Single-beat packets therefore take 2 cycles each, with a minimum of 1 idle cycle between packets.
- Tag free:
  - Triggered by rc_desc_valid & rc_request_completed & rc_tag < TAG_COUNT.
  - If the tag is busy, clear it; if not busy, set tag_error and change nothing.
  - rc_tag >= TAG_COUNT is ignored.
  - A free and an allocation in the same cycle are both applied, and tags_outstanding reflects the net change.
  - A tag freed in cycle N is allocatable from N+1.
- Pool full: read requesters are ineligible; writes still proceed, with no head-of-line blocking.
- A requester dropping req_valid mid-packet stalls the port; the grant holds until last.
- Simultaneous write and read eligibility is resolved purely by round-robin order.

Test Plan:
- Requester 0 sends a single-beat write to addr 0x1_0000_0000 with 4 DW → after 1 cycle, rq_valid=1, rq_is_write=1, rq_tag=0xFF, rq_addr=0x1_0000_0000, rq_dword_count=4; the pointer moves to 1.
- All 3 requesters hold single-beat writes continuously → grant order 0,1,2,0,1,2, one packet every 2 cycles.
- Requester 1 sends a 3-beat write while requester 0 is valid → 3 consecutive beats from requester 1; requester 0 is granted only after rq_last; rq_ready low for 2 cycles stretches the packet without a grant change.
- Requester 2 issues 32 reads with no completions → tags 0..31 are issued in order and tags_outstanding=32; a 33rd read waits while a write from requester 0 is still granted. Then rc_desc_valid with rc_tag=5 and rc_request_completed=1 → rc_owner=2, rc_owner_valid=1; the next read receives tag 5.
- Completion with rc_tag=7 while tag 7 is free → tag_error=1 (sticky) and tags_outstanding is unchanged; rc_tag=0x40 → ignored.
- Assert rst during beat 2 of a 4-beat packet with 3 tags busy → the next cycle shows rq_valid=0, tags_outstanding=0, FSM in ARB, pointer 0.
